// File: rtl/modulation_segment_streamer.sv
// Buffers upstream modulation segments in a small FIFO and streams them out with
// symbol/frame boundary tags and a start/valid/busy frame handshake.
module modulation_segment_streamer #(
    parameter int SEG_W        = 32,
    parameter int SEGS_PER_SYM = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       num_syms,
    input  logic [SEG_W-1:0] segment,
    input  logic             seg_valid,
    input  logic             sample_ready,
    output logic [SEG_W-1:0] sample_out,
    output logic             sample_valid,
    output logic             sym_last,
    output logic             frame_last,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (SEGS_PER_SYM > 1) ? $clog2(SEGS_PER_SYM) : 1;
    localparam logic [CW-1:0] SEG_LAST = CW'(SEGS_PER_SYM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        num_syms_q;
    logic [7:0]        sym_cnt;
    logic [CW-1:0]     seg_cnt;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       rd_ptr_inc;
    logic [SEG_W+1:0]  mem [FIFO_DEPTH];
    logic [SEG_W+1:0]  head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              is_sym_last;
    logic              is_frame_last;
    logic              start_ok;

    assign rd_ptr_inc    = rd_ptr + 1'b1;
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop           = !fifo_empty && sample_ready;
    assign push_req      = (state == RUN) && seg_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push          = push_req && (!fifo_full || pop);
    assign is_sym_last   = (seg_cnt == SEG_LAST);
    assign is_frame_last = is_sym_last && (sym_cnt == num_syms_q - 8'd1);
    assign start_ok      = (state == IDLE) && start;

    // Head is masked while empty so stale, unreset storage never reaches the port.
    assign head         = mem[rd_ptr[AW-1:0]];
    assign sample_valid = !fifo_empty;
    assign sample_out   = fifo_empty ? '0 : head[SEG_W-1:0];
    assign sym_last     = !fifo_empty && head[SEG_W];
    assign frame_last   = !fifo_empty && head[SEG_W+1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_syms == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (push_req && is_frame_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty || (pop && (rd_ptr_inc == wr_ptr))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                valid     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Dropped segments are still counted to keep symbol alignment with upstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_syms_q <= 8'd0;
            sym_cnt    <= 8'd0;
            seg_cnt    <= '0;
            overflow   <= 1'b0;
        end else if (start_ok) begin
            num_syms_q <= num_syms;
            sym_cnt    <= 8'd0;
            seg_cnt    <= '0;
            overflow   <= 1'b0;
        end else if (push_req) begin
            if (is_sym_last) begin
                seg_cnt <= '0;
                sym_cnt <= sym_cnt + 8'd1;
            end else begin
                seg_cnt <= seg_cnt + 1'b1;
            end
            if (fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {is_frame_last, is_sym_last, segment};
        end
    end

endmodule

// File: doc/modulation_segment_streamer.md
# modulation_segment_streamer

Downstream stage of the per-branch modulation calculation blocks (the `If__V_*_else_calculation` family). It accepts the delayed 32-bit `segment` words those blocks produce, buffers them in a small FIFO and presents them as a flow-controlled sample stream. It also tags symbol and frame boundaries and reports frame completion through the pipe's usual `start`/`valid`/`busy` handshake.

## Interface
- `SEG_W`, 32: segment/sample width in bits.
- `SEGS_PER_SYM`, 8: segments per modulated symbol (≥1).
- `FIFO_DEPTH`, 8: buffer entries (power of two, ≥2).
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low; asserted (0) forces all state to reset values immediately.
- `start` input 1: one-cycle frame arm pulse; honoured only in IDLE.
- `num_syms` input 8: frame length in symbols, latched on accepted `start`.
- `segment` input SEG_W: segment word from the upstream calculation stage.
- `seg_valid` input 1: `segment` is valid this cycle (no backpressure upstream).
- `sample_ready` input 1: downstream accepts the sample this cycle.
- `sample_out` output SEG_W: FIFO head word.
- `sample_valid` output 1: FIFO non-empty.
- `sym_last` output 1: head word is the last segment of a symbol.
- `frame_last` output 1: head word is the last segment of the frame.
- `valid` output 1: one-cycle frame-complete pulse.
- `busy` output 1: high whenever state ≠ IDLE.
- `overflow` output 1: sticky; a segment was dropped on a full FIFO.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` when `num_syms` ≠ 0. Latches `num_syms`, clears counters and `overflow`.
  - IDLE → DONE on `start` when `num_syms` = 0. Latches, clears `overflow`.
  - RUN → DRAIN in the cycle the final frame segment is counted, i.e. segment `num_syms*SEGS_PER_SYM`.
  - DRAIN → DONE when the FIFO is empty, including the cycle the last pop completes the drain.
  - DONE → IDLE unconditionally after one cycle. `valid`=1 while in DONE.
- Input side, RUN only:
  - Each `seg_valid` cycle counts one segment. `seg_cnt` (0..SEGS_PER_SYM-1) wraps and increments `sym_cnt`.
  - A push stores {`segment`, `sym_last`=(`seg_cnt`=SEGS_PER_SYM-1), `frame_last`=(last symbol AND `sym_last`)}.
  - `seg_valid` in IDLE, DRAIN or DONE is ignored: no push, no count.
- Full FIFO:
  - A push with no simultaneous pop is dropped and sets `overflow`.
  - The dropped segment still counts, to preserve symbol alignment with upstream.
  - If a push and a pop occur together while full, both complete and there is no drop.
- Output side: a pop occurs when `sample_valid` & `sample_ready`. `sample_out`, `sym_last` and `frame_last` are combinational from the FIFO head.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit. Full is indicated by equal indices with differing wrap bits.
- Symbol counter is 8 bits; the frame-end compare uses the latched `num_syms`.
- `start` outside IDLE is ignored and has no effect on the latched length.
- Reset mid-frame: FIFO is emptied (pointers zeroed), state → IDLE, and no `valid` pulse is issued.
- `overflow` holds until the next accepted `start` or reset.

## Timing
- Reset values: `sample_out`=0, `sample_valid`=0, `sym_last`=0, `frame_last`=0, `valid`=0, `busy`=0, `overflow`=0, state=IDLE.
- `start` sampled at edge k → `busy`=1 from cycle k+1. Segments are accepted from cycle k+1.
- Push at edge n → `sample_valid`=1 in cycle n+1 (1-cycle latency).
- Zero-bubble streaming at full rate when `sample_ready` is held 1.
- `valid` is high for exactly 1 cycle, the cycle after the FIFO becomes empty in DRAIN. `busy` drops the cycle after that.
- `num_syms`=0: `valid` appears at cycle k+1 and `busy` is high for exactly that one cycle.

## Test plan
- Basic frame:
  - Stimulus: `num_syms`=2, `SEGS_PER_SYM`=8, 16 consecutive `seg_valid` with values 0x100..0x10F, `sample_ready`=1.
  - Required: samples 0x100..0x10F in order; `sym_last` on 0x107 and 0x10F; `frame_last` only on 0x10F; one `valid` pulse; `overflow`=0.
- Backpressure/overflow:
  - Stimulus: `sample_ready`=0, 10 segments with `num_syms`=2.
  - Required: first 8 stored; segments 9–10 dropped; `overflow`=1; the 8 heads drain in order after `sample_ready`=1; frame completes after 16 counted segments.
- Full with simultaneous push+pop:
  - Stimulus: fill FIFO to 8, then assert `seg_valid` and `sample_ready` together for 4 cycles.
  - Required: no drop; `overflow` stays 0; order preserved.
- Zero-length frame:
  - Stimulus: `start` with `num_syms`=0.
  - Required: `valid`=1 and `busy`=1 for one cycle at k+1; `sample_valid` never asserts.
- Ignored inputs:
  - Stimulus: `start` pulsed mid-RUN with a different `num_syms`; `seg_valid` asserted in IDLE.
  - Required: frame length unchanged; no pushes while in IDLE.
- Async reset mid-frame:
  - Stimulus: drop `reset` to 0 for one cycle with 5 entries buffered.
  - Required: all outputs 0 immediately; state IDLE; no `valid` pulse; next frame runs cleanly.
